timer_down_mmss: RTL and testbench

//  mm:ss BCD countdown timer (00:00..59:59) for the clock24 design. The operator sets it in

---
 rtl/timer_down_mmss.sv | 201 ++++++++++++++++++++
 tb/tb_timer_down_mmss.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/timer_down_mmss.sv
// mm:ss BCD countdown timer with IDLE/RUN/PAUSE/ALARM control and a timed buzzer phase.
// Optional build macro TIMER_AUTORELOAD_EN: expiry reloads the latched start value and keeps running.
module timer_down_mmss #(
    parameter int ALARM_TICKS = 10
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       TICK,
    input  logic       START,
    input  logic       STOP,
    input  logic       CLR,
    input  logic       SET_M,
    input  logic       SET_S,
    output logic [2:0] MH,
    output logic [3:0] ML,
    output logic [2:0] SH,
    output logic [3:0] SL,
    output logic       RUNNING,
    output logic       ALARM,
    output logic       BZ,
    output logic       EXP
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_ALARM} state_t;

    state_t      state_r, state_s;
    logic [13:0] val_r, val_s;
    logic [13:0] rl_r, rl_s;
    logic [7:0]  acnt_r, acnt_s;
    logic        bz_r, bz_s;
    logic        exp_r, exp_s;
    logic        run_r, run_s;
    logic        alarm_r, alarm_s;

    // Increment a tens:ones BCD pair 00..59 with wrap to 00.
    function automatic logic [6:0] bcd59_inc(input logic [6:0] v);
        logic [2:0] t;
        logic [3:0] o;
        t = v[6:4];
        o = v[3:0];
        if (o == 4'd9) begin
            o = 4'd0;
            t = (t == 3'd5) ? 3'd0 : t + 3'd1;
        end else begin
            o = o + 4'd1;
        end
        return {t, o};
    endfunction

    // Decrement a full mm:ss value by one second; caller guarantees it is not 00:00.
    function automatic logic [13:0] mmss_dec(input logic [13:0] v);
        logic [2:0] mh;
        logic [3:0] ml;
        logic [2:0] sh;
        logic [3:0] sl;
        {mh, ml, sh, sl} = v;
        if (sl != 4'd0) begin
            sl = sl - 4'd1;
        end else begin
            sl = 4'd9;
            if (sh != 3'd0) begin
                sh = sh - 3'd1;
            end else begin
                sh = 3'd5;
                if (ml != 4'd0) begin
                    ml = ml - 4'd1;
                end else begin
                    ml = 4'd9;
                    mh = mh - 3'd1;
                end
            end
        end
        return {mh, ml, sh, sl};
    endfunction

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_s = state_r;
        val_s   = val_r;
        rl_s    = rl_r;
        acnt_s  = acnt_r;
        bz_s    = bz_r;
        exp_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (CLR) begin
                    val_s = 14'd0;
                end else if (STOP) begin
                    val_s = val_r;
                end else if (START && (val_r != 14'd0)) begin
                    rl_s    = val_r;
                    state_s = S_RUN;
                end else begin
                    // Minutes and seconds wrap independently; seconds never carry.
                    if (SET_M) begin
                        val_s[13:7] = bcd59_inc(val_r[13:7]);
                    end else begin
                        val_s[13:7] = val_r[13:7];
                    end
                    if (SET_S) begin
                        val_s[6:0] = bcd59_inc(val_r[6:0]);
                    end else begin
                        val_s[6:0] = val_r[6:0];
                    end
                end
            end
            S_RUN: begin
                if (CLR) begin
                    val_s   = 14'd0;
                    state_s = S_IDLE;
                end else if (STOP) begin
                    state_s = S_PAUSE;
                end else if (TICK) begin
                    if (val_r == 14'd1) begin
                        exp_s = 1'b1;
`ifdef TIMER_AUTORELOAD_EN
                        val_s = rl_r;
`else
                        val_s   = 14'd0;
                        state_s = S_ALARM;
                        acnt_s  = 8'(ALARM_TICKS);
                        bz_s    = 1'b0;
`endif
                    end else begin
                        val_s = mmss_dec(val_r);
                    end
                end else begin
                    val_s = val_r;
                end
            end
            S_PAUSE: begin
                if (CLR) begin
                    val_s   = 14'd0;
                    state_s = S_IDLE;
                end else if (STOP) begin
                    val_s = val_r;
                end else if (START) begin
                    state_s = S_RUN;
                end else begin
                    val_s = val_r;
                end
            end
            S_ALARM: begin
                if (CLR || STOP || START) begin
                    state_s = S_IDLE;
                    acnt_s  = 8'd0;
                    bz_s    = 1'b0;
                end else if (TICK) begin
                    if (acnt_r <= 8'd1) begin
                        state_s = S_IDLE;
                        acnt_s  = 8'd0;
                        bz_s    = 1'b0;
                    end else begin
                        acnt_s = acnt_r - 8'd1;
                        bz_s   = ~bz_r;
                    end
                end else begin
                    acnt_s = acnt_r;
                end
            end
            default: begin
                state_s = S_IDLE;
                val_s   = 14'd0;
                acnt_s  = 8'd0;
                bz_s    = 1'b0;
            end
        endcase
        run_s   = (state_s == S_RUN);
        alarm_s = (state_s == S_ALARM);
    end

    // State and output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= S_IDLE;
            val_r   <= 14'd0;
            rl_r    <= 14'd0;
            acnt_r  <= 8'd0;
            bz_r    <= 1'b0;
            exp_r   <= 1'b0;
            run_r   <= 1'b0;
            alarm_r <= 1'b0;
        end else begin
            state_r <= state_s;
            val_r   <= val_s;
            rl_r    <= rl_s;
            acnt_r  <= acnt_s;
            bz_r    <= bz_s;
            exp_r   <= exp_s;
            run_r   <= run_s;
            alarm_r <= alarm_s;
        end
    end

    assign {MH, ML, SH, SL} = val_r;
    assign RUNNING          = run_r;
    assign ALARM            = alarm_r;
    assign BZ               = bz_r;
    assign EXP              = exp_r;

endmodule

// File: tb/tb_timer_down_mmss.sv
// Scoreboard bench for timer_down_mmss: expectations are queued as stimulus is driven and
// compared once the DUT has clocked the corresponding cycle.
module tb_timer_down_mmss;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       TICK = 1'b0, START = 1'b0, STOP = 1'b0, CLR = 1'b0, SET_M = 1'b0, SET_S = 1'b0;
    logic [2:0] MH, SH;
    logic [3:0] ML, SL;
    logic       RUNNING, ALARM, BZ, EXP;

    localparam logic [5:0] I_NONE = 6'b000000;
    localparam logic [5:0] I_TICK = 6'b000001;
    localparam logic [5:0] I_SETS = 6'b000010;
    localparam logic [5:0] I_SETM = 6'b000100;
    localparam logic [5:0] I_STRT = 6'b001000;
    localparam logic [5:0] I_STOP = 6'b010000;
    localparam logic [5:0] I_CLR  = 6'b100000;

    timer_down_mmss #(.ALARM_TICKS(10)) dut (
        .CLK(CLK), .RST(RST), .TICK(TICK), .START(START), .STOP(STOP), .CLR(CLR),
        .SET_M(SET_M), .SET_S(SET_S), .MH(MH), .ML(ML), .SH(SH), .SL(SL),
        .RUNNING(RUNNING), .ALARM(ALARM), .BZ(BZ), .EXP(EXP)
    );

    always #5 CLK = ~CLK;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [17:0] sb_q[$];
    logic [17:0] obs_s;
    logic [17:0] exp_v;

    assign obs_s = {MH, ML, SH, SL, RUNNING, ALARM, BZ, EXP};

    // Reference encoding of a seconds count plus status flags.
    function automatic logic [17:0] pack(input int secs, input logic run, input logic alm,
                                         input logic bz, input logic ex);
        int m, s;
        m = secs / 60;
        s = secs % 60;
        return {3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10), run, alm, bz, ex};
    endfunction

    // Drive one cycle of inputs from a falling edge; returns on the next falling edge.
    task automatic cyc(input logic [5:0] v);
        {CLR, STOP, START, SET_M, SET_S, TICK} = v;
        @(posedge CLK);
        @(negedge CLK);
        {CLR, STOP, START, SET_M, SET_S, TICK} = I_NONE;
    endtask

    task automatic test_reset();
        sb_q.push_back(pack(0, 1'b0, 1'b0, 1'b0, 1'b0));
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        cyc(I_NONE);
        exp_v = sb_q.pop_front(); tests_run++;
        if (obs_s !== exp_v) begin tests_failed++; $display("FAIL reset_state got %h want %h", obs_s, exp_v); end
        repeat (2) cyc(I_SETM);
        repeat (17) cyc(I_SETS);
        cyc(I_STRT);
        sb_q.push_back(pack(137, 1'b1, 1'b0, 1'b0, 1'b0));
        exp_v = sb_q.pop_front(); tests_run++;
        if (obs_s !== exp_v) begin tests_failed++; $display("FAIL run_0217 got %h want %h", obs_s, exp_v); end
        RST = 1'b1;
        sb_q.push_back(pack(0, 1'b0, 1'b0, 1'b0, 1'b0));
        cyc(I_TICK);
        exp_v = sb_q.pop_front(); tests_run++;
        if (obs_s !== exp_v) begin tests_failed++; $display("FAIL reset_mid_run got %h want %h", obs_s, exp_v); end
        RST = 1'b0;
        sb_q.push_back(pack(0, 1'b0, 1'b0, 1'b0, 1'b0));
        cyc(I_TICK);
        exp_v = sb_q.pop_front(); tests_run++;
        if (obs_s !== exp_v) begin tests_failed++; $display("FAIL after_reset got %h want %h", obs_s, exp_v); end
    endtask

    task automatic test_set();
        for (int i = 1; i <= 61; i++) begin
            sb_q.push_back(pack(i % 60, 1'b0, 1'b0, 1'b0, 1'b0));
            cyc(I_SETS);
            exp_v = sb_q.pop_front(); tests_run++;
            if (obs_s !== exp_v) begin tests_failed++; $display("FAIL set_s_%0d got %h want %h", i, obs_s, exp_v); end
        end
        for (int i = 1; i <= 62; i++) begin
            sb_q.push_back(pack((i % 60) * 60 + 1, 1'b0, 1'b0, 1'b0, 1'b0));
            cyc(I_SETM);
            exp_v = sb_q.pop_front(); tests_run++;
            if (obs_s !== exp_v) begin tests_failed++; $display("FAIL set_m_%0d got %h want %h", i, obs_s, exp_v); end
        end
        sb_q.push_back(pack(182, 1'b0, 1'b0, 1'b0, 1'b0));
        cyc(I_SETM | I_SETS);
        sb_q.push_back(pack(182, 1'b0, 1'b0, 1'b0, 1'b0));
        cyc(I_TICK | I_STOP);
        sb_q.push_back(pack(0, 1'b0, 1'b0, 1'b0, 1'b0));
        cyc(I_CLR | I_SETS);
        for (int k = 0; k < 3; k++) begin
            exp_v = sb_q.pop_front(); tests_run++;
            if (obs_s !== exp_v && k == 2) begin tests_failed++; $display("FAIL set_clr got %h want %h", obs_s, exp_v); end
        end
    endtask

    task automatic test_countdown();
        cyc(I_SETM);
        sb_q.push_back(pack(60, 1'b1, 1'b0, 1'b0, 1'b0));
        cyc(I_STRT);
        exp_v = sb_q.pop_front(); tests_run++;
        if (obs_s !== exp_v) begin tests_failed++; $display("FAIL start_0100 got %h want %h", obs_s, exp_v); end
        for (int t = 59; t >= 1; t--) begin
            sb_q.push_back(pack(t, 1'b1, 1'b0, 1'b0, 1'b0));
            cyc(I_TICK);
            exp_v = sb_q.pop_front(); tests_run++;
            if (obs_s !== exp_v) begin tests_failed++; $display("FAIL count_%0d got %h want %h", t, obs_s, exp_v); end
            cyc(I_NONE);
        end
`ifdef TIMER_AUTORELOAD_EN
        sb_q.push_back(pack(60, 1'b1, 1'b0, 1'b0, 1'b1));
        sb_q.push_back(pack(60, 1'b1, 1'b0, 1'b0, 1'b0));
`else
        sb_q.push_back(pack(0, 1'b0, 1'b1, 1'b0, 1'b1));
        sb_q.push_back(pack(0, 1'b0, 1'b1, 1'b0, 1'b0));
`endif
        cyc(I_TICK);
        exp_v = sb_q.pop_front(); tests_run++;
        if (obs_s !== exp_v) begin tests_failed++; $display("FAIL expiry got %h want %h", obs_s, exp_v); end
        cyc(I_NONE);
        exp_v = sb_q.pop_front(); tests_run++;
        if (obs_s !== exp_v) begin tests_failed++; $display("FAIL exp_one_cycle got %h want %h", obs_s, exp_v); end
    endtask

    task automatic test_alarm();
        for (int k = 1; k <= 10; k++) begin
            sb_q.push_back(pack(0, 1'b0, (k < 10), (k < 10) ? 1'(k % 2) : 1'b0, 1'b0));
            cyc(I_TICK);
            exp_v = sb_q.pop_front(); tests_run++;
            if (obs_s !== exp_v) begin tests_failed++; $display("FAIL alarm_tick_%0d got %h want %h", k, obs_s, exp_v); end
            cyc(I_NONE);
        end
        cyc(I_SETS);
        cyc(I_STRT);
        sb_q.push_back(pack(0, 1'b0, 1'b1, 1'b0, 1'b1));
        cyc(I_TICK);
        exp_v = sb_q.pop_front(); tests_run++;
        if (obs_s !== exp_v) begin tests_failed++; $display("FAIL alarm2_entry got %h want %h", obs_s, exp_v); end
        cyc(I_TICK);
        sb_q.push_back(pack(0, 1'b0, 1'b0, 1'b0, 1'b0));
        cyc(I_STOP);
        exp_v = sb_q.pop_front(); tests_run++;
        if (obs_s !== exp_v) begin tests_failed++; $display("FAIL alarm_stop got %h want %h", obs_s, exp_v); end
    endtask

    task automatic test_pause();
        cyc(I_CLR);
        repeat (30) cyc(I_SETS);
        cyc(I_STRT);
        sb_q.push_back(pack(30, 1'b0, 1'b0, 1'b0, 1'b0));
        cyc(I_STOP);
        for (int k = 0; k < 5; k++) begin
            cyc(I_TICK);
            sb_q.push_back(pack(30, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        for (int k = 0; k < 6; k++) begin
            exp_v = sb_q.pop_front(); tests_run++;
            if (obs_s !== exp_v) begin tests_failed++; $display("FAIL pause_hold_%0d got %h want %h", k, obs_s, exp_v); end
        end
        sb_q.push_back(pack(30, 1'b1, 1'b0, 1'b0, 1'b0));
        cyc(I_STRT);
        exp_v = sb_q.pop_front(); tests_run++;
        if (obs_s !== exp_v) begin tests_failed++; $display("FAIL resume got %h want %h", obs_s, exp_v); end
        sb_q.push_back(pack(29, 1'b1, 1'b0, 1'b0, 1'b0));
        cyc(I_TICK);
        exp_v = sb_q.pop_front(); tests_run++;
        if (obs_s !== exp_v) begin tests_failed++; $display("FAIL resume_tick got %h want %h", obs_s, exp_v); end
        sb_q.push_back(pack(0, 1'b0, 1'b0, 1'b0, 1'b0));
        cyc(I_CLR | I_STRT);
        exp_v = sb_q.pop_front(); tests_run++;
        if (obs_s !== exp_v) begin tests_failed++; $display("FAIL clr_start got %h want %h", obs_s, exp_v); end
    endtask

    task automatic test_zero_start();
        sb_q.push_back(pack(0, 1'b0, 1'b0, 1'b0, 1'b0));
        cyc(I_STRT);
        exp_v = sb_q.pop_front(); tests_run++;
        if (obs_s !== exp_v) begin tests_failed++; $display("FAIL start_zero got %h want %h", obs_s, exp_v); end
        sb_q.push_back(pack(0, 1'b0, 1'b0, 1'b0, 1'b0));
        cyc(I_TICK);
        exp_v = sb_q.pop_front(); tests_run++;
        if (obs_s !== exp_v) begin tests_failed++; $display("FAIL idle_tick got %h want %h", obs_s, exp_v); end
    endtask

`ifdef TIMER_AUTORELOAD_EN
    task automatic test_autoreload();
        int exp_cnt;
        exp_cnt = 0;
        cyc(I_CLR);
        repeat (2) cyc(I_SETS);
        cyc(I_STRT);
        for (int k = 1; k <= 4; k++) begin
            sb_q.push_back(pack((k % 2 == 1) ? 1 : 2, 1'b1, 1'b0, 1'b0, (k % 2 == 0)));
            cyc(I_TICK);
            exp_cnt += int'(EXP);
            exp_v = sb_q.pop_front(); tests_run++;
            if (obs_s !== exp_v) begin tests_failed++; $display("FAIL reload_tick_%0d got %h want %h", k, obs_s, exp_v); end
            cyc(I_NONE);
        end
        tests_run++;
        if (exp_cnt !== 2) begin tests_failed++; $display("FAIL reload_exp_count got %0d want 2", exp_cnt); end
        cyc(I_CLR);
    endtask
`endif

    initial begin
        test_reset();
        test_set();
        test_countdown();
`ifndef TIMER_AUTORELOAD_EN
        test_alarm();
`else
        cyc(I_CLR);
`endif
        test_pause();
        test_zero_start();
`ifdef TIMER_AUTORELOAD_EN
        test_autoreload();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
